pe_acc_param: RTL and testbench

PE_ACC_PARAM -- requirements
Module: pe_acc_param

---
 rtl/pe_acc_param.sv | 125 ++++++++++++
 tb/tb_pe_acc_param.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_acc_param.sv
// Systolic processing element: forwards A/B east/south and accumulates
// K signed products per result, with optional saturation and overflow flag.
module pe_acc_param #(
    parameter int DW  = 8,
    parameter int AW  = 32,
    parameter int K   = 4,
    parameter int SAT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic signed [DW-1:0] a_in,
    input  logic signed [DW-1:0] b_in,
    input  logic                 flush,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic                 valid_fwd,
    output logic signed [AW-1:0] y_out,
    output logic                 y_valid,
    output logic                 overflow,
    output logic                 busy
);

    localparam int PW = 2 * DW;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] LAST = CW'(K - 1);
    localparam logic signed [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

    generate
        if ((AW < 2 * DW) || (K < 1)) begin : g_bad_params
            $error("pe_acc_param: need AW >= 2*DW and K >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic signed [AW-1:0]  r_acc;
    logic signed [AW-1:0]  w_acc_nxt;
    logic                  r_ovf_acc;
    logic                  w_ovf_acc_nxt;
    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_prod_x;
    logic signed [AW-1:0]  w_base;
    logic signed [AW-1:0]  w_sum;
    logic signed [AW-1:0]  w_sum_fix;
    logic                  w_add_ovf;
    logic                  w_done;

    assign w_prod   = PW'(a_in) * PW'(b_in);
    assign w_prod_x = AW'(w_prod);
    assign w_base   = (r_state == ACCUM) ? r_acc : '0;
    assign w_sum    = w_base + w_prod_x;

    // Overflow only possible when both addends share a sign.
    assign w_add_ovf = (w_base[AW-1] == w_prod_x[AW-1]) &&
                       (w_sum[AW-1] != w_base[AW-1]);

    always_comb begin
        w_sum_fix = w_sum;
        if ((SAT != 0) && w_add_ovf) begin
            w_sum_fix = w_base[AW-1] ? MINV : MAXV;
        end
    end

    assign w_done = valid_in && !flush && (r_cnt == LAST);
    assign busy   = (r_state == ACCUM);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_nxt     = r_acc;
        w_ovf_acc_nxt = r_ovf_acc;
        if (flush || w_done) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_acc_nxt     = '0;
            w_ovf_acc_nxt = 1'b0;
        end else if (valid_in) begin
            w_state_nxt   = ACCUM;
            w_cnt_nxt     = r_cnt + CW'(1);
            w_acc_nxt     = w_sum_fix;
            w_ovf_acc_nxt = r_ovf_acc | w_add_ovf;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_ovf_acc <= w_ovf_acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_fwd <= 1'b0;
            y_out     <= '0;
            y_valid   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_fwd <= valid_in;
            y_valid   <= w_done;
            if (w_done) begin
                y_out    <= w_sum_fix;
                overflow <= r_ovf_acc | w_add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_pe_acc_param.sv
// Bench for pe_acc_param: four parameterisations share one stimulus
// stream and are compared every cycle against an arithmetic model.
module tb_pe_acc_param;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic valid_in = 1'b0;
    logic flush = 1'b0;
    logic signed [7:0] a_in = '0;
    logic signed [7:0] b_in = '0;

    logic signed [7:0] ao [4];
    logic signed [7:0] bo [4];
    logic vf [4];
    logic yv [4];
    logic ov [4];
    logic bz [4];
    logic signed [31:0] y0;
    logic signed [15:0] y1;
    logic signed [15:0] y2;
    logic signed [31:0] y3;

    int npass = 0;
    int ntot = 0;

    int kp [4] = '{4, 4, 4, 1};
    int awp [4] = '{32, 16, 16, 32};
    int satp [4] = '{0, 0, 1, 0};

    longint m_acc [4];
    longint m_y [4];
    int m_cnt [4];
    bit m_oa [4];
    bit m_yv [4];
    bit m_ov [4];
    logic signed [7:0] m_a;
    logic signed [7:0] m_b;
    bit m_v;

    always #5 clk = ~clk;

    pe_acc_param #(.DW(8), .AW(32), .K(4), .SAT(0)) u0 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .flush(flush),
        .a_out(ao[0]), .b_out(bo[0]), .valid_fwd(vf[0]),
        .y_out(y0), .y_valid(yv[0]), .overflow(ov[0]), .busy(bz[0])
    );

    pe_acc_param #(.DW(8), .AW(16), .K(4), .SAT(0)) u1 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .flush(flush),
        .a_out(ao[1]), .b_out(bo[1]), .valid_fwd(vf[1]),
        .y_out(y1), .y_valid(yv[1]), .overflow(ov[1]), .busy(bz[1])
    );

    pe_acc_param #(.DW(8), .AW(16), .K(4), .SAT(1)) u2 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .flush(flush),
        .a_out(ao[2]), .b_out(bo[2]), .valid_fwd(vf[2]),
        .y_out(y2), .y_valid(yv[2]), .overflow(ov[2]), .busy(bz[2])
    );

    pe_acc_param #(.DW(8), .AW(32), .K(1), .SAT(0)) u3 (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .a_in(a_in), .b_in(b_in), .flush(flush),
        .a_out(ao[3]), .b_out(bo[3]), .valid_fwd(vf[3]),
        .y_out(y3), .y_valid(yv[3]), .overflow(ov[3]), .busy(bz[3])
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint wrapv(input longint s, input int aw);
        longint m;
        longint r;
        m = longint'(1) << aw;
        r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic model_reset();
        m_a = '0;
        m_b = '0;
        m_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0;
            m_y[i] = 0;
            m_cnt[i] = 0;
            m_oa[i] = 1'b0;
            m_yv[i] = 1'b0;
            m_ov[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input logic signed [7:0] a,
                              input logic signed [7:0] b, input bit f);
        if (!reset) begin
            model_reset();
            return;
        end
        m_a = a;
        m_b = b;
        m_v = v;
        for (int i = 0; i < 4; i++) begin
            longint p;
            longint hi;
            longint lo;
            longint s;
            bit o;
            m_yv[i] = 1'b0;
            if (f) begin
                m_acc[i] = 0;
                m_cnt[i] = 0;
                m_oa[i] = 1'b0;
            end else if (v) begin
                p = longint'(a) * longint'(b);
                hi = (longint'(1) << (awp[i] - 1)) - 1;
                lo = -hi - 1;
                s = m_acc[i] + p;
                o = (s > hi) || (s < lo);
                if (o) s = (satp[i] != 0) ? ((s > hi) ? hi : lo)
                                          : wrapv(s, awp[i]);
                if (m_cnt[i] + 1 == kp[i]) begin
                    m_y[i] = s;
                    m_yv[i] = 1'b1;
                    m_ov[i] = m_oa[i] | o;
                    m_acc[i] = 0;
                    m_cnt[i] = 0;
                    m_oa[i] = 1'b0;
                end else begin
                    m_acc[i] = s;
                    m_cnt[i]++;
                    m_oa[i] = m_oa[i] | o;
                end
            end
        end
    endtask

    task automatic check_all();
        logic signed [63:0] ya [4];
        ya[0] = y0;
        ya[1] = y1;
        ya[2] = y2;
        ya[3] = y3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d.a_out", i), ao[i], m_a);
            chk($sformatf("u%0d.b_out", i), bo[i], m_b);
            chk($sformatf("u%0d.valid_fwd", i), vf[i], m_v);
            chk($sformatf("u%0d.y_out", i), ya[i], m_y[i]);
            chk($sformatf("u%0d.y_valid", i), yv[i], m_yv[i]);
            chk($sformatf("u%0d.overflow", i), ov[i], m_ov[i]);
            chk($sformatf("u%0d.busy", i), bz[i], m_cnt[i] != 0);
        end
    endtask

    task automatic cyc(input bit v, input logic signed [7:0] a,
                       input logic signed [7:0] b, input bit f);
        valid_in = v;
        a_in = a;
        b_in = b;
        flush = f;
        @(posedge clk);
        model_step(v, a, b, f);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b1;
    endtask

    int pulses;
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    logic signed [7:0] ext [3] = '{8'sd127, -8'sd128, -8'sd127};

    initial begin
        model_reset();
        valid_in = 1'b1;
        a_in = 8'sd9;
        b_in = 8'sd9;
        #1;
        check_all();
        cyc(1, 8'sd9, 8'sd9, 0);
        cyc(1, -8'sd5, 8'sd7, 0);
        release_reset();

        cyc(1, 8'sd1, 8'sd2, 0);
        cyc(1, 8'sd3, 8'sd4, 0);
        cyc(1, 8'sd5, 8'sd6, 0);
        chk("r037_y_valid_early", yv[0], 1'b0);
        cyc(1, 8'sd7, 8'sd8, 0);
        chk("r037_y", y0, 100);
        chk("r037_y_valid", yv[0], 1'b1);
        chk("r037_ovf", ov[0], 1'b0);

        pulses = 0;
        cyc(1, 8'sd1, 8'sd2, 0);
        pulses += int'(yv[0]);
        chk("r038_busy1", bz[0], 1'b1);
        cyc(0, 8'sd0, 8'sd0, 0);
        pulses += int'(yv[0]);
        cyc(1, 8'sd3, 8'sd4, 0);
        pulses += int'(yv[0]);
        cyc(0, 8'sd0, 8'sd0, 0);
        pulses += int'(yv[0]);
        cyc(1, 8'sd5, 8'sd6, 0);
        pulses += int'(yv[0]);
        chk("r038_busy3", bz[0], 1'b1);
        cyc(0, 8'sd0, 8'sd0, 0);
        pulses += int'(yv[0]);
        cyc(1, 8'sd7, 8'sd8, 0);
        pulses += int'(yv[0]);
        chk("r038_y", y0, 100);
        chk("r038_busy_end", bz[0], 1'b0);
        cyc(0, 8'sd0, 8'sd0, 0);
        pulses += int'(yv[0]);
        chk("r038_pulses", pulses, 1);
        chk("r038_y_hold", y0, 100);

        for (int i = 0; i < 4; i++) cyc(1, 8'sd127, 8'sd127, 0);
        chk("r039_wrap_y", y1, -1020);
        chk("r039_wrap_ovf", ov[1], 1'b1);
        chk("r039_sat_y", y2, 32767);
        chk("r039_sat_ovf", ov[2], 1'b1);

        cyc(1, -8'sd128, -8'sd128, 0);
        chk("r040_y1", y3, 16384);
        chk("r040_yv1", yv[3], 1'b1);
        cyc(1, -8'sd3, 8'sd5, 0);
        chk("r040_y2", y3, -15);
        chk("r040_yv2", yv[3], 1'b1);
        cyc(0, 8'sd0, 8'sd0, 1);

        pulses = 0;
        cyc(1, 8'sd3, 8'sd3, 0);
        pulses += int'(yv[0]);
        cyc(1, 8'sd4, 8'sd4, 0);
        pulses += int'(yv[0]);
        cyc(1, 8'sd5, 8'sd5, 1);
        pulses += int'(yv[0]);
        chk("r041_busy_after_flush", bz[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'sd1, 8'sd1, 0);
            pulses += int'(yv[0]);
        end
        chk("r041_no_pulse", pulses, 0);
        cyc(1, 8'sd1, 8'sd1, 0);
        chk("r041_y", y0, 4);
        chk("r041_yv", yv[0], 1'b1);

        cyc(1, 8'sd6, 8'sd6, 0);
        cyc(1, 8'sd6, 8'sd6, 0);
        do_reset();
        chk("r042_busy_rst", bz[0], 1'b0);
        cyc(1, 8'sd2, 8'sd2, 0);
        release_reset();
        for (int i = 0; i < 4; i++) cyc(1, 8'sd2, 8'sd2, 0);
        chk("r042_y", y0, 16);
        chk("r042_yv", yv[0], 1'b1);

        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(3) == 0) ? ext[$urandom_range(2)]
                                          : 8'($urandom);
            rb = ($urandom_range(3) == 0) ? ext[$urandom_range(2)]
                                          : 8'($urandom);
            if (n == 211) begin
                do_reset();
                cyc(1, ra, rb, 0);
                release_reset();
            end else begin
                cyc($urandom_range(9) < 7, ra, rb,
                    $urandom_range(19) == 0);
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
